// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter: grants one of NUM_M active-low requesters using fixed
// priority or round-robin, with an optional hold limit that evicts a hogging owner.
module bus_arbiter_rr #(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned RR_MODE  = 1,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned OWN_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_M-1:0] req_,
  output logic [NUM_M-1:0] grnt_,
  output logic [OWN_W-1:0] owner,
  output logic             owner_vld,
  output logic             preempt
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_RELEASE
  } state_t;

  state_t             r_state;
  logic [NUM_M-1:0]   r_grnt;
  logic [OWN_W-1:0]   r_owner;
  logic [OWN_W-1:0]   r_last;
  logic               r_vld;
  logic               r_preempt;
  logic [HOLD_W-1:0]  r_hold;

  logic [NUM_M-1:0]   w_pend;
  logic [NUM_M-1:0]   w_own_oh;
  logic [NUM_M-1:0]   w_others;
  logic [OWN_W-1:0]   w_win_idle;
  logic [OWN_W-1:0]   w_win_hand;
  logic [OWN_W-1:0]   w_win_rel;

  // Winner over a candidate mask: lowest index, or first index after base (wrapping).
  function automatic logic [OWN_W-1:0] pick(input logic [NUM_M-1:0] cand,
                                            input logic [OWN_W-1:0] base);
    logic [OWN_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    if (RR_MODE != 0) begin
      for (int unsigned i = 1; i <= NUM_M; i++) begin
        idx = (32'(base) + i) % NUM_M;
        if (!found && cand[OWN_W'(idx)]) begin
          win   = OWN_W'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_M; i++) begin
        if (!found && cand[OWN_W'(i)]) begin
          win   = OWN_W'(i);
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  function automatic logic [NUM_M-1:0] grant_of(input logic [OWN_W-1:0] idx);
    return ~(NUM_M'(1) << idx);
  endfunction

  always_comb begin
    w_pend     = ~req_;
    w_own_oh   = NUM_M'(1) << r_owner;
    w_others   = w_pend & ~w_own_oh;
    w_win_idle = pick(w_pend, r_last);
    w_win_hand = pick(w_pend, r_owner);
    w_win_rel  = pick(w_others, r_owner);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grnt    <= '1;
      r_owner   <= '0;
      r_last    <= OWN_W'(NUM_M - 1);
      r_vld     <= 1'b0;
      r_preempt <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_pend) begin
            r_grnt  <= grant_of(w_win_idle);
            r_owner <= w_win_idle;
            r_vld   <= 1'b1;
            r_hold  <= '0;
            r_state <= ST_OWNED;
          end
        end

        ST_OWNED: begin
          if (!w_pend[r_owner]) begin
            // Voluntary release takes precedence over hold-limit expiry.
            r_last <= r_owner;
            r_hold <= '0;
            if (|w_pend) begin
              r_grnt  <= grant_of(w_win_hand);
              r_owner <= w_win_hand;
            end else begin
              r_grnt  <= '1;
              r_vld   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else if (MAX_HOLD != 0 && r_hold == HOLD_LAST && |w_others) begin
            r_grnt    <= '1;
            r_vld     <= 1'b0;
            r_preempt <= 1'b1;
            r_last    <= r_owner;
            r_hold    <= '0;
            r_state   <= ST_RELEASE;
          end else if (MAX_HOLD != 0 && r_hold != HOLD_LAST) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end

        ST_RELEASE: begin
          r_hold <= '0;
          if (|w_others) begin
            r_grnt  <= grant_of(w_win_rel);
            r_owner <= w_win_rel;
            r_vld   <= 1'b1;
            r_state <= ST_OWNED;
          end else if (|w_pend) begin
            r_grnt  <= grant_of(w_win_hand);
            r_owner <= w_win_hand;
            r_vld   <= 1'b1;
            r_state <= ST_OWNED;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_grnt  <= '1;
          r_vld   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grnt_     = r_grnt;
  assign owner     = r_owner;
  assign owner_vld = r_vld;
  assign preempt   = r_preempt;

endmodule
